writeback: RTL and testbench
============================

WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter: WIDTH, 32, datapath width in bits.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: stall_w_i  input  1  hold MEM/WB register contents.
REQ-005 Port: flush_w_i  input  1  load a bubble into MEM/WB register.
REQ-006 Port: reg_write_m_i  input  1  register-file write request from memory stage.
REQ-007 Port: result_src_m_i  input  2  result select: 00 ALU, 01 load data, 10 PC+4, 11 ALU.
REQ-008 Port: rd_m_i  input  5  destination register index.
REQ-009 Port: funct3_m_i  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 Port: alu_result_m_i  input  WIDTH  ALU result / data address.
REQ-011 Port: read_data_m_i  input  WIDTH  raw word from data RAM, valid in memory stage.
REQ-012 Port: pc_plus_4_m_i  input  WIDTH  PC+4 of instruction.
REQ-013 Port: result_w_o  output  WIDTH  value to write to register file.
REQ-014 Port: rd_w_o  output  5  destination register index to register file and hazard unit.
REQ-015 Port: reg_write_w_o  output  1  qualified register-file write enable.
REQ-016 Port: valid_w_o  output  1  writeback slot holds a real instruction.
REQ-017 Port: load_misalign_w_o  output  1  misaligned load detected in writeback slot.

Function
REQ-018 MEM/WB register SHALL capture valid, reg_write, result_src, rd, funct3, alu_result, read_data, pc_plus_4 on each rising clk edge; latency memory->writeback exactly 1 cycle.
REQ-019 Captured valid SHALL be 1 on a normal load; flush_w_i=1 SHALL load valid=0, reg_write=0, rd=0, all data fields 0.
REQ-020 stall_w_i=1 with flush_w_i=0 SHALL hold every register field unchanged.
REQ-021 flush_w_i SHALL take priority over stall_w_i when both asserted in the same cycle.
REQ-022 Load extraction SHALL be combinational from registered fields, byte offset = alu_result[1:0].
REQ-023 LB/LBU: byte at offset (0:[7:0],1:[15:8],2:[23:16],3:[31:24]), sign/zero-extended to WIDTH.
REQ-024 LH/LHU: offset[1]=0 selects [15:0], offset[1]=1 selects [31:16], sign/zero-extended.
REQ-025 LW and any undefined funct3 (011,110,111): full word unchanged.
REQ-026 Misaligned = LH/LHU with offset[0]=1, or LW with offset!=00; LB/LBU never misaligned.
REQ-027 load_misalign_w_o = valid AND result_src==01 AND misaligned; otherwise 0.
REQ-028 result_w_o SHALL follow result_src: 00/11 alu_result, 01 extracted load data, 10 pc_plus_4.
REQ-029 reg_write_w_o = valid AND reg_write AND (rd!=0) AND NOT load_misalign_w_o.
REQ-030 rd_w_o SHALL be the registered rd regardless of qualification.
REQ-031 Misaligned load result_w_o SHALL still present the extracted value per REQ-023..025 (write suppressed only).

Reset
REQ-032 rst_n=0 SHALL immediately, without clock, clear all register fields to 0.
REQ-033 During and after reset until first capture: result_w_o=0, rd_w_o=0, reg_write_w_o=0, valid_w_o=0, load_misalign_w_o=0.
REQ-034 Reset asserted mid-stall or mid-flush SHALL override both; first edge after rst_n rises SHALL capture normally.

Verification
REQ-035 LB, alu_result=0x1003, read_data=0x80FF_1234, rd=5, reg_write=1, src=01 -> next cycle result_w_o=0xFFFF_FF80, reg_write_w_o=1, rd_w_o=5.
REQ-036 LHU offset 2, read_data=0x8001_0000 -> result_w_o=0x0000_8001; LH same -> 0xFFFF_8001.
REQ-037 LW alu_result=0x2002, reg_write=1 -> load_misalign_w_o=1, reg_write_w_o=0; same with src=00 -> misalign=0, result=0x2002.
REQ-038 src=10, pc_plus_4=0x104, rd=1 -> result_w_o=0x104; repeat with rd=0 -> reg_write_w_o=0.
REQ-039 Capture instr A, then stall 3 cycles with changing inputs -> outputs hold A; assert stall+flush together -> valid_w_o=0, reg_write_w_o=0, rd_w_o=0 next cycle.
REQ-040 Assert rst_n=0 between clock edges with valid instr held -> all outputs 0 before next edge; release -> next edge captures inputs.

Source files
------------

// File: rtl/writeback_if.sv
// Memory-to-writeback boundary signals for the writeback stage.
// The master side drives memory-stage state and pipeline control;
// the slave side (the writeback stage) returns the register-file write.
interface writeback_if #(
   parameter int WIDTH = 32
);
   // Pipeline control
   logic             stall_w_i;
   logic             flush_w_i;

   // Memory-stage instruction state
   logic             reg_write_m_i;
   logic [1:0]       result_src_m_i;
   logic [4:0]       rd_m_i;
   logic [2:0]       funct3_m_i;
   logic [WIDTH-1:0] alu_result_m_i;
   logic [WIDTH-1:0] read_data_m_i;
   logic [WIDTH-1:0] pc_plus_4_m_i;

   // Writeback results
   logic [WIDTH-1:0] result_w_o;
   logic [4:0]       rd_w_o;
   logic             reg_write_w_o;
   logic             valid_w_o;
   logic             load_misalign_w_o;

   modport master (
      output stall_w_i, flush_w_i,
      output reg_write_m_i, result_src_m_i, rd_m_i, funct3_m_i,
      output alu_result_m_i, read_data_m_i, pc_plus_4_m_i,
      input  result_w_o, rd_w_o, reg_write_w_o, valid_w_o, load_misalign_w_o
   );

   modport slave (
      input  stall_w_i, flush_w_i,
      input  reg_write_m_i, result_src_m_i, rd_m_i, funct3_m_i,
      input  alu_result_m_i, read_data_m_i, pc_plus_4_m_i,
      output result_w_o, rd_w_o, reg_write_w_o, valid_w_o, load_misalign_w_o
   );
endinterface

// File: rtl/writeback.sv
// Writeback stage: MEM/WB pipeline register, load byte/half extraction
// with sign/zero extension, misaligned-load detection and result select.
// Load extraction assumes WIDTH >= 32 (the data RAM returns 32-bit words).
module writeback #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   writeback_if.slave wb
);

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [1:0] SRC_LOAD = 2'b01;
   localparam logic [1:0] SRC_PC4  = 2'b10;

   typedef struct packed {
      logic             valid;
      logic             reg_write;
      logic [1:0]       result_src;
      logic [4:0]       rd;
      logic [2:0]       funct3;
      logic [WIDTH-1:0] alu_result;
      logic [WIDTH-1:0] read_data;
      logic [WIDTH-1:0] pc_plus_4;
   } mem_wb_t;

   mem_wb_t          mem_wb_q;
   mem_wb_t          mem_wb_d;

   logic [1:0]       offset;
   logic [7:0]       load_byte;
   logic [15:0]      load_half;
   logic [WIDTH-1:0] load_data;
   logic             misaligned;
   logic             load_misalign;
   logic [WIDTH-1:0] result;

   // Next MEM/WB contents: flush beats stall, stall holds, otherwise capture.
   always_comb begin
      // NOTE: default assignment first so no path leaves mem_wb_d unassigned (no latch).
      mem_wb_d = mem_wb_q;
      if (wb.flush_w_i) begin
         mem_wb_d = '0;
      end else if (!wb.stall_w_i) begin
         mem_wb_d.valid      = 1'b1;
         mem_wb_d.reg_write  = wb.reg_write_m_i;
         mem_wb_d.result_src = wb.result_src_m_i;
         mem_wb_d.rd         = wb.rd_m_i;
         mem_wb_d.funct3     = wb.funct3_m_i;
         mem_wb_d.alu_result = wb.alu_result_m_i;
         mem_wb_d.read_data  = wb.read_data_m_i;
         mem_wb_d.pc_plus_4  = wb.pc_plus_4_m_i;
      end
   end

   // MEM/WB register with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the register is cleared asynchronously so outputs drop to 0 without a clock edge.
      if (!rst_n) begin
         mem_wb_q <= '0;
      end else begin
         // NOTE: non-blocking so every field updates together from pre-edge values.
         mem_wb_q <= mem_wb_d;
      end
   end

   // Load data extraction and alignment check from the registered fields.
   always_comb begin
      offset     = mem_wb_q.alu_result[1:0];
      load_byte  = mem_wb_q.read_data[{offset, 3'b000} +: 8];
      load_half  = offset[1] ? mem_wb_q.read_data[31:16] : mem_wb_q.read_data[15:0];
      load_data  = mem_wb_q.read_data;
      misaligned = 1'b0;
      unique case (mem_wb_q.funct3)
         F3_LB:  load_data = {{(WIDTH-8){load_byte[7]}}, load_byte};
         F3_LBU: load_data = {{(WIDTH-8){1'b0}}, load_byte};
         F3_LH: begin
            load_data  = {{(WIDTH-16){load_half[15]}}, load_half};
            misaligned = offset[0];
         end
         F3_LHU: begin
            load_data  = {{(WIDTH-16){1'b0}}, load_half};
            misaligned = offset[0];
         end
         F3_LW:  misaligned = (offset != 2'b00);
         default: ;  // undefined funct3 passes the full word through
      endcase
   end

   // Result select; 00 and 11 both return the ALU result.
   always_comb begin
      unique case (mem_wb_q.result_src)
         SRC_LOAD: result = load_data;
         SRC_PC4:  result = mem_wb_q.pc_plus_4;
         default:  result = mem_wb_q.alu_result;
      endcase
   end

   // A misaligned load still presents its extracted value; only the write is dropped.
   assign load_misalign = mem_wb_q.valid && (mem_wb_q.result_src == SRC_LOAD) && misaligned;

   assign wb.result_w_o        = result;
   assign wb.rd_w_o            = mem_wb_q.rd;
   assign wb.valid_w_o         = mem_wb_q.valid;
   assign wb.load_misalign_w_o = load_misalign;
   assign wb.reg_write_w_o     = mem_wb_q.valid && mem_wb_q.reg_write &&
                                 (mem_wb_q.rd != 5'd0) && !load_misalign;

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for the writeback stage: stimulus pushes hand-computed
// expectations, a monitor pops and compares once per sample point.
module tb_writeback;

   localparam int WIDTH = 32;

   typedef struct {
      string       name;
      logic [31:0] result;
      logic [4:0]  rd;
      logic        reg_write;
      logic        valid;
      logic        misalign;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t sb[$];
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   event sample_ev;

   writeback_if #(.WIDTH(WIDTH)) wb ();

   writeback #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wb    (wb.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input string field,
                        input logic [31:0] actual, input logic [31:0] expected);
      total_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, actual, expected);
   endtask

   // Monitor: compares outputs at every falling edge (or forced sample) with a pending entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or sample_ev);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check(e.name, "result",    wb.result_w_o,               e.result);
            check(e.name, "rd",        {27'd0, wb.rd_w_o},          {27'd0, e.rd});
            check(e.name, "reg_write", {31'd0, wb.reg_write_w_o},   {31'd0, e.reg_write});
            check(e.name, "valid",     {31'd0, wb.valid_w_o},       {31'd0, e.valid});
            check(e.name, "misalign",  {31'd0, wb.load_misalign_w_o}, {31'd0, e.misalign});
         end
      end
   end

   task automatic drive(input logic stall, input logic flush, input logic rw,
                        input logic [1:0] src, input logic [4:0] rd, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] data, input logic [31:0] pc);
      wb.stall_w_i      = stall;
      wb.flush_w_i      = flush;
      wb.reg_write_m_i  = rw;
      wb.result_src_m_i = src;
      wb.rd_m_i         = rd;
      wb.funct3_m_i     = f3;
      wb.alu_result_m_i = alu;
      wb.read_data_m_i  = data;
      wb.pc_plus_4_m_i  = pc;
   endtask

   function automatic exp_t mk(input string name, input logic [31:0] result, input logic [4:0] rd,
                               input logic rw, input logic valid, input logic mis);
      exp_t e;
      e.name = name; e.result = result; e.rd = rd;
      e.reg_write = rw; e.valid = valid; e.misalign = mis;
      return e;
   endfunction

   // One clock edge; the expectation is the state visible after that edge.
   task automatic step(input exp_t e);
      @(posedge clk);
      sb.push_back(e);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 2'b01, 5'd3, 3'b010, 32'h1111_2222, 32'h3333_4444, 32'h8);
      sb.push_back(mk("reset", 32'h0, 5'd0, 1'b0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // LB offset 3, negative byte
      drive(0, 0, 1, 2'b01, 5'd5, 3'b000, 32'h1003, 32'h80FF_1234, 32'h0);
      step(mk("lb_off3", 32'hFFFF_FF80, 5'd5, 1, 1, 0));
      // LHU / LH offset 2
      drive(0, 0, 1, 2'b01, 5'd6, 3'b101, 32'h2002, 32'h8001_0000, 32'h0);
      step(mk("lhu_off2", 32'h0000_8001, 5'd6, 1, 1, 0));
      drive(0, 0, 1, 2'b01, 5'd6, 3'b001, 32'h2002, 32'h8001_0000, 32'h0);
      step(mk("lh_off2", 32'hFFFF_8001, 5'd6, 1, 1, 0));
      // LW misaligned: value still presented, write dropped
      drive(0, 0, 1, 2'b01, 5'd7, 3'b010, 32'h2002, 32'hDEAD_BEEF, 32'h0);
      step(mk("lw_misalign", 32'hDEAD_BEEF, 5'd7, 0, 1, 1));
      drive(0, 0, 1, 2'b00, 5'd7, 3'b010, 32'h2002, 32'hDEAD_BEEF, 32'h0);
      step(mk("alu_not_load", 32'h0000_2002, 5'd7, 1, 1, 0));
      // PC+4 select, then rd=0 suppresses the write
      drive(0, 0, 1, 2'b10, 5'd1, 3'b000, 32'h55, 32'h0, 32'h104);
      step(mk("pc4_rd1", 32'h0000_0104, 5'd1, 1, 1, 0));
      drive(0, 0, 1, 2'b10, 5'd0, 3'b000, 32'h55, 32'h0, 32'h104);
      step(mk("pc4_rd0", 32'h0000_0104, 5'd0, 0, 1, 0));
      // LBU offset 1, LB offset 2
      drive(0, 0, 1, 2'b01, 5'd9, 3'b100, 32'h11, 32'h1234_A6CD, 32'h0);
      step(mk("lbu_off1", 32'h0000_00A6, 5'd9, 1, 1, 0));
      drive(0, 0, 1, 2'b01, 5'd9, 3'b000, 32'h22, 32'h0085_0000, 32'h0);
      step(mk("lb_off2", 32'hFFFF_FF85, 5'd9, 1, 1, 0));
      // LH odd offset: misaligned, low half extracted
      drive(0, 0, 1, 2'b01, 5'd4, 3'b001, 32'h101, 32'h0000_8234, 32'h0);
      step(mk("lh_misalign", 32'hFFFF_8234, 5'd4, 0, 1, 1));
      // Undefined funct3 passes full word and is never misaligned
      drive(0, 0, 1, 2'b01, 5'd8, 3'b011, 32'h3, 32'hCAFE_F00D, 32'h0);
      step(mk("f3_undef", 32'hCAFE_F00D, 5'd8, 1, 1, 0));
      // src=11 selects ALU; reg_write=0 suppresses the write
      drive(0, 0, 0, 2'b11, 5'd3, 3'b000, 32'h55AA, 32'h1, 32'h2);
      step(mk("src11_nowrite", 32'h0000_55AA, 5'd3, 0, 1, 0));
      // Flush alone
      drive(0, 1, 1, 2'b10, 5'd12, 3'b000, 32'h77, 32'h0, 32'h200);
      step(mk("flush", 32'h0, 5'd0, 0, 0, 0));

      // Capture A, stall three cycles with changing inputs
      drive(0, 0, 1, 2'b00, 5'd10, 3'b000, 32'hA5A5, 32'h0, 32'h0);
      step(mk("cap_a", 32'h0000_A5A5, 5'd10, 1, 1, 0));
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 2'b10, 5'(20 + i), 3'b010, 32'h100 + 32'(i), 32'h5, 32'h900 + 32'(i));
         step(mk($sformatf("stall_%0d", i), 32'h0000_A5A5, 5'd10, 1, 1, 0));
      end
      // Stall and flush together: flush wins
      drive(1, 1, 1, 2'b00, 5'd11, 3'b000, 32'hBEEF, 32'h0, 32'h0);
      step(mk("stall_flush", 32'h0, 5'd0, 0, 0, 0));
      drive(0, 0, 1, 2'b00, 5'd11, 3'b000, 32'hBEEF, 32'h0, 32'h0);
      step(mk("after_flush", 32'h0000_BEEF, 5'd11, 1, 1, 0));

      // Asynchronous reset between edges, with a valid instruction held and stall raised
      drive(0, 0, 1, 2'b01, 5'd13, 3'b000, 32'h1, 32'h0000_9C00, 32'h0);
      step(mk("cap_b", 32'hFFFF_FF9C, 5'd13, 1, 1, 0));
      @(negedge clk);
      #1;
      rst_n        = 1'b0;
      wb.stall_w_i = 1'b1;
      #1;
      sb.push_back(mk("async_rst", 32'h0, 5'd0, 0, 0, 0));
      ->sample_ev;
      @(posedge clk);
      #1;
      rst_n        = 1'b1;
      wb.stall_w_i = 1'b0;
      step(mk("post_rst_cap", 32'hFFFF_FF9C, 5'd13, 1, 1, 0));

      @(negedge clk);
      #1;
      check("scoreboard", "pending", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
